// File: rtl/pong_pkg.sv
// Shared VGA timing, colour and pixel-pipeline definitions for the Pong renderer.
package pong_pkg;

    // 640x480 @ 60 Hz: active, front porch, sync pulse, back porch
    localparam int SCREEN_H_RES  = 640;
    localparam int H_FRONT_PORCH = 16;
    localparam int H_SYNC_PULSE  = 96;
    localparam int H_BACK_PORCH  = 48;
    localparam int H_TOTAL       = SCREEN_H_RES + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;

    localparam int SCREEN_V_RES  = 480;
    localparam int V_FRONT_PORCH = 10;
    localparam int V_SYNC_PULSE  = 2;
    localparam int V_BACK_PORCH  = 33;
    localparam int V_TOTAL       = SCREEN_V_RES + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;

    localparam int SCREEN_BORDER = 4;

    localparam int H_CNT_W = 10;
    localparam int V_CNT_W = 10;
    localparam int X_POS_W = H_CNT_W;
    localparam int Y_POS_W = V_CNT_W;

    // Counter-width versions of the constants so comparisons stay width-matched
    localparam logic [H_CNT_W-1:0] H_LAST       = H_CNT_W'(H_TOTAL - 1);
    localparam logic [H_CNT_W-1:0] H_ACT_END    = H_CNT_W'(SCREEN_H_RES);
    localparam logic [H_CNT_W-1:0] H_SYNC_FIRST = H_CNT_W'(SCREEN_H_RES + H_FRONT_PORCH);
    localparam logic [H_CNT_W-1:0] H_SYNC_LAST  = H_CNT_W'(SCREEN_H_RES + H_FRONT_PORCH + H_SYNC_PULSE - 1);
    localparam logic [H_CNT_W-1:0] H_NET_LEFT   = H_CNT_W'(SCREEN_H_RES / 2 - 1);
    localparam logic [H_CNT_W-1:0] H_NET_RIGHT  = H_CNT_W'(SCREEN_H_RES / 2);

    localparam logic [V_CNT_W-1:0] V_LAST       = V_CNT_W'(V_TOTAL - 1);
    localparam logic [V_CNT_W-1:0] V_LATCH_PREV = V_CNT_W'(V_TOTAL - 2);
    localparam logic [V_CNT_W-1:0] V_ACT_LAST   = V_CNT_W'(SCREEN_V_RES - 1);
    localparam logic [V_CNT_W-1:0] V_ACT_END    = V_CNT_W'(SCREEN_V_RES);
    localparam logic [V_CNT_W-1:0] V_SYNC_FIRST = V_CNT_W'(SCREEN_V_RES + V_FRONT_PORCH);
    localparam logic [V_CNT_W-1:0] V_SYNC_LAST  = V_CNT_W'(SCREEN_V_RES + V_FRONT_PORCH + V_SYNC_PULSE - 1);
    localparam logic [V_CNT_W-1:0] V_BORDER_TOP = V_CNT_W'(SCREEN_BORDER);
    localparam logic [V_CNT_W-1:0] V_BORDER_BOT = V_CNT_W'(SCREEN_V_RES - SCREEN_BORDER);

    // Colours, 4 bits per channel as {R, G, B}
    localparam int RGB_W = 12;
    typedef logic [RGB_W-1:0] rgb_t;

    localparam rgb_t COL_BG     = 12'h112;
    localparam rgb_t COL_BALL   = 12'hFF0;
    localparam rgb_t COL_PADDLE = 12'hFFF;
    localparam rgb_t COL_NET    = 12'h888;
    localparam rgb_t COL_BORDER = 12'h0F0;

    // Sprite slots; the value doubles as the index into the shadow/hit arrays
    typedef enum logic [1:0] {
        SPR_BALL   = 2'd0,
        SPR_PLAYER = 2'd1,
        SPR_ENEMY  = 2'd2
    } sprite_e;

    localparam int NUM_SPRITES = 3;

    // Per-pixel flags captured in the first pipeline stage
    typedef struct packed {
        logic active;
        logic ball;
        logic paddle;
        logic net;
        logic border;
        logic hs_pulse;
        logic vs_pulse;
    } pix_flags_t;

    // Priority mux: ball over paddles over net over border over background
    function automatic rgb_t select_colour(input pix_flags_t f);
        rgb_t col;
        if (!f.active)     col = '0;
        else if (f.ball)   col = COL_BALL;
        else if (f.paddle) col = COL_PADDLE;
        else if (f.net)    col = COL_NET;
        else if (f.border) col = COL_BORDER;
        else               col = COL_BG;
        return col;
    endfunction

endpackage

// File: rtl/config.svh
// Sprite geometry for the Pong game, shared by the renderer and game logic.
`ifndef PONG_CONFIG_SVH
`define PONG_CONFIG_SVH

`define PADDLE_WIDTH  8
`define PADDLE_HEIGHT 64
`define BALL_SIDE     8

`endif

// File: rtl/vga_timing.sv
// Pixel-enable divider, 800x525 raster counters, raw sync pulses and frame strobes.
module vga_timing
    import pong_pkg::*;
#(
    parameter int PIX_DIV = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    output logic [H_CNT_W-1:0] h_cnt,
    output logic [V_CNT_W-1:0] v_cnt,
    output logic               hsync_pulse,
    output logic               vsync_pulse,
    output logic               shadow_load,
    output logic               new_frame_o
);

    localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

    logic [DIV_W-1:0]   div_reg, div_next;
    logic [H_CNT_W-1:0] h_cnt_reg, h_cnt_next;
    logic [V_CNT_W-1:0] v_cnt_reg, v_cnt_next;
    logic               pix_en;
    logic               line_end;
    logic               frame_start;
    logic               new_frame_reg;

    // Next-state for divider and raster counters; strobes fire on the enable
    // that moves the counters onto the named position
    always_comb begin
        pix_en      = (div_reg == DIV_LAST);
        div_next    = pix_en ? '0 : div_reg + 1'b1;
        line_end    = pix_en && (h_cnt_reg == H_LAST);
        h_cnt_next  = h_cnt_reg;
        v_cnt_next  = v_cnt_reg;
        if (pix_en) begin
            h_cnt_next = line_end ? '0 : h_cnt_reg + 1'b1;
        end
        if (line_end) begin
            v_cnt_next = (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + 1'b1;
        end
        frame_start = line_end && (v_cnt_reg == V_ACT_LAST);
        shadow_load = line_end && (v_cnt_reg == V_LATCH_PREV);
        hsync_pulse = (h_cnt_reg >= H_SYNC_FIRST) && (h_cnt_reg <= H_SYNC_LAST);
        vsync_pulse = (v_cnt_reg >= V_SYNC_FIRST) && (v_cnt_reg <= V_SYNC_LAST);
    end

    // Timing state registers; reset restarts the raster at (0, 0)
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_reg       <= '0;
            h_cnt_reg     <= '0;
            v_cnt_reg     <= '0;
            new_frame_reg <= 1'b0;
        end else begin
            div_reg       <= div_next;
            h_cnt_reg     <= h_cnt_next;
            v_cnt_reg     <= v_cnt_next;
            new_frame_reg <= frame_start;
        end
    end

    assign h_cnt       = h_cnt_reg;
    assign v_cnt       = v_cnt_reg;
    assign new_frame_o = new_frame_reg;

endmodule

// File: rtl/pong_renderer.sv
// Pong VGA renderer: per-frame position shadows, sprite hit tests and a
// two-stage colour/sync pipeline behind the vga_timing raster generator.
`include "config.svh"

module pong_renderer
    import pong_pkg::*;
#(
    parameter int PIX_DIV = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [X_POS_W-1:0] player_x_i,
    input  logic [X_POS_W-1:0] enemy_x_i,
    input  logic [X_POS_W-1:0] ball_x_i,
    input  logic [Y_POS_W-1:0] player_y_i,
    input  logic [Y_POS_W-1:0] enemy_y_i,
    input  logic [Y_POS_W-1:0] ball_y_i,
    output logic               new_frame_o,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic [RGB_W-1:0]   rgb_o
);

    logic [H_CNT_W-1:0]     h_cnt;
    logic [V_CNT_W-1:0]     v_cnt;
    logic                   hsync_pulse;
    logic                   vsync_pulse;
    logic                   shadow_load;

    logic [X_POS_W-1:0]     pos_x [NUM_SPRITES];
    logic [Y_POS_W-1:0]     pos_y [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] hit;

    pix_flags_t             s1_next, s1_reg;
    rgb_t                   rgb_reg;
    logic                   hsync_reg;
    logic                   vsync_reg;

    vga_timing #(
        .PIX_DIV (PIX_DIV)
    ) u_timing (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .hsync_pulse (hsync_pulse),
        .vsync_pulse (vsync_pulse),
        .shadow_load (shadow_load),
        .new_frame_o (new_frame_o)
    );

    // Slot order follows sprite_e: ball, player, enemy
    assign pos_x = '{ball_x_i, player_x_i, enemy_x_i};
    assign pos_y = '{ball_y_i, player_y_i, enemy_y_i};

    generate
        for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_sprite
            localparam int SPR_W = (gi == int'(SPR_BALL)) ? `BALL_SIDE : `PADDLE_WIDTH;
            localparam int SPR_H = (gi == int'(SPR_BALL)) ? `BALL_SIDE : `PADDLE_HEIGHT;

            logic [X_POS_W-1:0] sx_reg;
            logic [Y_POS_W-1:0] sy_reg;
            logic [X_POS_W:0]   right_edge;
            logic [Y_POS_W:0]   bottom_edge;

            // Shadow copy taken once per frame in blanking so a frame never tears
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    sx_reg <= '0;
                    sy_reg <= '0;
                end else if (shadow_load) begin
                    sx_reg <= pos_x[gi];
                    sy_reg <= pos_y[gi];
                end
            end

            // One extra bit keeps right/bottom edges from wrapping near the limit
            assign right_edge  = {1'b0, sx_reg} + (X_POS_W+1)'(SPR_W);
            assign bottom_edge = {1'b0, sy_reg} + (Y_POS_W+1)'(SPR_H);
            assign hit[gi] = (h_cnt >= sx_reg) && ({1'b0, h_cnt} < right_edge) &&
                             (v_cnt >= sy_reg) && ({1'b0, v_cnt} < bottom_edge);
        end
    endgenerate

    // Stage-1 flags for the current raster position
    always_comb begin
        s1_next          = '0;
        s1_next.active   = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
        s1_next.ball     = hit[SPR_BALL];
        s1_next.paddle   = hit[SPR_PLAYER] | hit[SPR_ENEMY];
        s1_next.net      = ((h_cnt == H_NET_LEFT) || (h_cnt == H_NET_RIGHT)) && !v_cnt[3];
        s1_next.border   = (v_cnt < V_BORDER_TOP) || (v_cnt >= V_BORDER_BOT);
        s1_next.hs_pulse = hsync_pulse;
        s1_next.vs_pulse = vsync_pulse;
    end

    // Two pipeline stages clocked every cycle so colour and syncs stay aligned
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_reg    <= '0;
            rgb_reg   <= '0;
            hsync_reg <= 1'b1;
            vsync_reg <= 1'b1;
        end else begin
            s1_reg    <= s1_next;
            rgb_reg   <= select_colour(s1_reg);
            hsync_reg <= ~s1_reg.hs_pulse;
            vsync_reg <= ~s1_reg.vs_pulse;
        end
    end

    assign rgb_o   = rgb_reg;
    assign hsync_o = hsync_reg;
    assign vsync_o = vsync_reg;

endmodule

// File: tb/tb_pong_renderer.sv
// Directed bench for pong_renderer: sync timing, frame strobe, sprite drawing,
// shadow latching and mid-frame reset, all at PIX_DIV = 2.
module tb_pong_renderer;

    localparam logic [11:0] C_BG     = 12'h112;
    localparam logic [11:0] C_BALL   = 12'hFF0;
    localparam logic [11:0] C_PADDLE = 12'hFFF;
    localparam logic [11:0] C_NET    = 12'h888;
    localparam logic [11:0] C_BORDER = 12'h0F0;
    localparam logic [11:0] C_OFF    = 12'h000;

    localparam longint FRAME_CLK = 840000;

    logic       clk;
    logic       rst_i;
    logic [9:0] player_x_i, enemy_x_i, ball_x_i;
    logic [9:0] player_y_i, enemy_y_i, ball_y_i;
    logic       new_frame_o, hsync_o, vsync_o;
    logic [11:0] rgb_o;

    int     checks   = 0;
    int     failures = 0;
    longint cyc      = 0;
    longint rel_cyc  = 0;
    int     nf_count = 0;

    pong_renderer #(
        .PIX_DIV (2)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .player_x_i (player_x_i),
        .enemy_x_i  (enemy_x_i),
        .ball_x_i   (ball_x_i),
        .player_y_i (player_y_i),
        .enemy_y_i  (enemy_y_i),
        .ball_y_i   (ball_y_i),
        .new_frame_o(new_frame_o),
        .hsync_o    (hsync_o),
        .vsync_o    (vsync_o),
        .rgb_o      (rgb_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_i === 1'b0 && new_frame_o === 1'b1) nf_count <= nf_count + 1;
    end

    initial begin
        #40000000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            $display("check %s observed=%0h expected=%0h ok", tag, obs, exp);
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the negedge after edge t (edge 1 = first edge with reset low)
    task automatic goto(input longint t);
        if (cyc > rel_cyc + t) begin
            checks++;
            failures++;
            $error("FAIL schedule observed=%0d expected<=%0d", cyc - rel_cyc, t);
        end
        while (cyc < rel_cyc + t) @(negedge clk);
    endtask

    // Output for pixel (x, y) of frame f appears two clocks after the counters reach it
    task automatic check_pix(input int f, input int x, input int y,
                             input logic [11:0] exp, input string tag);
        goto(longint'(f) * FRAME_CLK + 2 * (longint'(y) * 800 + x) + 2);
        chk(tag, {20'd0, rgb_o}, {20'd0, exp});
    endtask

    // First hsync_o low edge and the following falling edge after a release
    task automatic hsync_timing(input string tag);
        longint first_low;
        longint next_fall;
        logic   prev;
        first_low = 0;
        next_fall = 0;
        for (longint t = 1; t <= 2000 && first_low == 0; t++) begin
            goto(t);
            if (hsync_o === 1'b0) first_low = t;
        end
        chk({tag, "_hsync_first_low"}, 32'(first_low), 32'd1314);
        prev = hsync_o;
        for (longint t = first_low + 1; t <= first_low + 2000 && next_fall == 0; t++) begin
            goto(t);
            if (prev === 1'b1 && hsync_o === 1'b0) next_fall = t;
            prev = hsync_o;
        end
        chk({tag, "_hsync_line_period"}, 32'(next_fall - first_low), 32'd1600);
    endtask

    initial begin
        rst_i      = 1'b1;
        ball_x_i   = 10'd100;
        ball_y_i   = 10'd200;
        player_x_i = 10'd100;
        player_y_i = 10'd204;
        enemy_x_i  = 10'd636;
        enemy_y_i  = 10'd300;

        repeat (5) @(negedge clk);
        chk("rst_rgb",       {20'd0, rgb_o}, 32'd0);
        chk("rst_hsync",     {31'd0, hsync_o}, 32'd1);
        chk("rst_vsync",     {31'd0, vsync_o}, 32'd1);
        chk("rst_new_frame", {31'd0, new_frame_o}, 32'd0);

        rst_i   = 1'b0;
        rel_cyc = cyc;

        hsync_timing("start");

        // Frame 0: shadows still hold the reset value (0, 0)
        check_pix(0, 5,   2,   C_BALL,   "f0_ball_at_origin");
        check_pix(0, 50,  2,   C_BORDER, "f0_top_border");
        check_pix(0, 319, 4,   C_NET,    "f0_net_dash_on");
        check_pix(0, 319, 8,   C_BG,     "f0_net_dash_off");
        check_pix(0, 700, 10,  C_OFF,    "f0_hblank_off");
        check_pix(0, 5,   20,  C_PADDLE, "f0_paddle_at_origin");
        check_pix(0, 639, 475, C_BG,     "f0_above_bottom_border");
        check_pix(0, 639, 477, C_BORDER, "f0_bottom_border");
        check_pix(0, 640, 477, C_OFF,    "f0_right_of_active");

        goto(767999);
        chk("nf_before_first", {31'd0, new_frame_o}, 32'd0);
        goto(768000);
        chk("nf_first_pulse", {31'd0, new_frame_o}, 32'd1);
        goto(768001);
        chk("nf_first_width", {31'd0, new_frame_o}, 32'd0);
        chk("nf_count_first", 32'(nf_count), 32'd1);

        goto(784001);
        chk("vsync_before_490", {31'd0, vsync_o}, 32'd1);
        goto(784002);
        chk("vsync_line_490", {31'd0, vsync_o}, 32'd0);
        goto(787201);
        chk("vsync_line_491", {31'd0, vsync_o}, 32'd0);
        goto(787202);
        chk("vsync_line_492", {31'd0, vsync_o}, 32'd1);

        // Frame 1: positions latched at (0, 524); move the ball mid-frame
        goto(FRAME_CLK + 2 * 100 * 800);
        ball_x_i = 10'd300;

        check_pix(1, 99,  200, C_BG,     "f1_left_of_ball");
        check_pix(1, 100, 200, C_BALL,   "f1_ball_first_pixel");
        check_pix(1, 108, 200, C_BG,     "f1_right_of_ball");
        check_pix(1, 107, 203, C_BALL,   "f1_ball_last_col");
        check_pix(1, 104, 205, C_BALL,   "f1_ball_over_paddle");
        check_pix(1, 100, 208, C_PADDLE, "f1_paddle_below_ball");
        check_pix(1, 107, 267, C_PADDLE, "f1_paddle_last_row");
        check_pix(1, 107, 268, C_BG,     "f1_below_paddle");
        check_pix(1, 636, 300, C_PADDLE, "f1_enemy_left");
        check_pix(1, 639, 300, C_PADDLE, "f1_enemy_at_edge");
        check_pix(1, 640, 300, C_OFF,    "f1_enemy_clipped");

        goto(FRAME_CLK + 767999);
        chk("nf_before_second", {31'd0, new_frame_o}, 32'd0);
        goto(FRAME_CLK + 768000);
        chk("nf_second_pulse", {31'd0, new_frame_o}, 32'd1);
        goto(FRAME_CLK + 768001);
        chk("nf_second_width", {31'd0, new_frame_o}, 32'd0);
        chk("nf_count_second", 32'(nf_count), 32'd2);

        // Frame 2: new ball position now visible
        check_pix(2, 100, 200, C_BG,   "f2_old_ball_gone");
        check_pix(2, 300, 200, C_BALL, "f2_new_ball_first");
        check_pix(2, 307, 207, C_BALL, "f2_new_ball_last");
        check_pix(2, 308, 207, C_BG,   "f2_new_ball_right");

        // Mid-frame reset while hsync is low at (700, 300)
        goto(2 * FRAME_CLK + 2 * (300 * 800 + 700) + 2);
        chk("pre_rst_hsync_low", {31'd0, hsync_o}, 32'd0);
        rst_i = 1'b1;
        @(negedge clk);
        chk("midrst_rgb",       {20'd0, rgb_o}, 32'd0);
        chk("midrst_hsync",     {31'd0, hsync_o}, 32'd1);
        chk("midrst_vsync",     {31'd0, vsync_o}, 32'd1);
        chk("midrst_new_frame", {31'd0, new_frame_o}, 32'd0);
        repeat (2) @(negedge clk);
        rst_i   = 1'b0;
        rel_cyc = cyc;

        hsync_timing("restart");
        check_pix(0, 5, 2, C_BALL, "restart_shadow_cleared");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
